// File: rtl/n8_pad_responder.sv
// rtl/n8_pad_responder.sv - N8 serial pad responder: latches eight buttons and shifts them out active-low
// Optional feature macro: N8_TURBO_EN (autofire on A/B via turbo_a/turbo_b)
module n8_pad_responder #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int TURBO_DIV      = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic ltch_in,
   input  logic pulse_in,
   input  logic a,
   input  logic b,
   input  logic select,
   input  logic start,
   input  logic up,
   input  logic down,
   input  logic left,
   input  logic right,
`ifdef N8_TURBO_EN
   input  logic turbo_a,
   input  logic turbo_b,
`endif
   output logic data_out,
   output logic busy,
   output logic frame_done
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   // Reject parameter values the counters cannot represent.
   if (TIMEOUT_CYCLES < 2 || TURBO_DIV < 1) begin : g_param_check
      $error("n8_pad_responder: TIMEOUT_CYCLES must be >= 2 and TURBO_DIV >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_EXH   = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      ltch_sync, pulse_sync;
   logic            ltch_s, pulse_s;
   logic            ltch_rise, ltch_fall, pulse_rise, pulse_fall;
   logic            any_edge;
   logic [7:0]      snap, snap_nxt;
   logic [2:0]      idx, idx_nxt;
   logic [WD_W-1:0] wd, wd_nxt;
   logic            data_nxt, fd_nxt;
   logic            a_eff, b_eff;
   logic [7:0]      btn;

`ifdef N8_TURBO_EN
   localparam int FC_W = $clog2(TURBO_DIV + 1);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(TURBO_DIV - 1);

   logic [FC_W-1:0] frame_cnt;
   logic            phase;

   // Autofire: the frame counter advances on every LOAD->SHIFT and flips the phase every TURBO_DIV frames.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
         phase     <= 1'b0;
      end else if (state == S_LOAD && state_nxt == S_SHIFT) begin
         if (frame_cnt == FC_LAST) begin
            frame_cnt <= '0;
            phase     <= ~phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   assign a_eff = a & ~(turbo_a & phase);
   assign b_eff = b & ~(turbo_b & phase);
`else
   assign a_eff = a;
   assign b_eff = b;
`endif

   assign btn      = {right, left, down, up, start, select, b_eff, a_eff};
   assign any_edge = ltch_rise | ltch_fall | pulse_rise | pulse_fall;
   assign busy     = (state == S_LOAD) || (state == S_SHIFT);

   // Two-flop synchronizers followed by a registered edge detector for latch and pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         ltch_sync  <= 2'b00;
         pulse_sync <= 2'b00;
         ltch_s     <= 1'b0;
         pulse_s    <= 1'b0;
         ltch_rise  <= 1'b0;
         ltch_fall  <= 1'b0;
         pulse_rise <= 1'b0;
         pulse_fall <= 1'b0;
      end else begin
         ltch_sync  <= {ltch_sync[0], ltch_in};
         pulse_sync <= {pulse_sync[0], pulse_in};
         ltch_s     <= ltch_sync[1];
         pulse_s    <= pulse_sync[1];
         ltch_rise  <= ltch_sync[1] & ~ltch_s;
         ltch_fall  <= ~ltch_sync[1] & ltch_s;
         pulse_rise <= pulse_sync[1] & ~pulse_s;
         pulse_fall <= ~pulse_sync[1] & pulse_s;
      end
   end

   // Frame sequencing: next state, bit index, snapshot, watchdog and the registered output values.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      snap_nxt  = snap;
      wd_nxt    = '0;
      fd_nxt    = 1'b0;
      data_nxt  = 1'b1;
      case (state)
         S_IDLE: begin
            if (ltch_rise) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (ltch_fall) state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            // Latch rise wins over a coincident pulse rise.
            if (ltch_rise) begin
               state_nxt = S_LOAD;
            end else if (pulse_rise) begin
               if (idx == 3'd7) begin
                  state_nxt = S_EXH;
                  fd_nxt    = 1'b1;
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end else if (!any_edge) begin
               if (wd == WD_LAST) state_nxt = S_IDLE;
               else               wd_nxt    = wd + 1'b1;
            end
         end
         S_EXH: begin
            if (ltch_rise) state_nxt = S_LOAD;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (state_nxt == S_LOAD || state_nxt == S_IDLE) idx_nxt = 3'd0;
      // Keep sampling while the latch is held; the value before the fall is what gets shifted.
      if (state_nxt == S_LOAD && ltch_s) snap_nxt = btn;
      case (state_nxt)
         S_IDLE:  data_nxt = 1'b1;
         S_EXH:   data_nxt = 1'b0;
         default: data_nxt = ~snap_nxt[idx_nxt];
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         idx        <= 3'd0;
         snap       <= 8'd0;
         wd         <= '0;
         data_out   <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         snap       <= snap_nxt;
         wd         <= wd_nxt;
         data_out   <= data_nxt;
         frame_done <= fd_nxt;
      end
   end

endmodule

// File: tb/tb_n8_pad_responder.sv
// tb/tb_n8_pad_responder.sv - self-checking bench for n8_pad_responder with a host-level reference model
module tb_n8_pad_responder;

   localparam int TO = 40;

   logic       clk = 1'b0;
   logic       reset;
   logic       ltch_in;
   logic       pulse_in;
   logic [7:0] btn;
   logic       a, b, select, start, up, down, left, right;
   logic       data_out, busy, frame_done;
`ifdef N8_TURBO_EN
   localparam int TDIV = 2;
   logic [1:0] turbo;
   logic       turbo_a, turbo_b;
   int         mframes;
   assign turbo_a = turbo[0];
   assign turbo_b = turbo[1];
`endif

   assign {right, left, down, up, start, select, b, a} = btn;

   int         vectors = 0;
   int         miscompares = 0;
   int         fd_cnt = 0;
   logic       chk_en = 1'b0;
   logic       exp_d = 1'b1;
   logic       exp_b = 1'b0;
   logic       last_d;
   logic [8:0] seq;

   always #5 clk = ~clk;

   n8_pad_responder #(.TIMEOUT_CYCLES(TO), .TURBO_DIV(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .ltch_in    (ltch_in),
      .pulse_in   (pulse_in),
      .a          (a),
      .b          (b),
      .select     (select),
      .start      (start),
      .up         (up),
      .down       (down),
      .left       (left),
      .right      (right),
`ifdef N8_TURBO_EN
      .turbo_a    (turbo_a),
      .turbo_b    (turbo_b),
`endif
      .data_out   (data_out),
      .busy       (busy),
      .frame_done (frame_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Buttons as the host should see them, with autofire applied from the model's own frame count.
   function automatic logic [7:0] eff_btn(input logic [7:0] bb);
      logic [7:0] e;
      e = bb;
`ifdef N8_TURBO_EN
      if (((mframes / TDIV) % 2) == 1) begin
         e[0] = bb[0] & ~turbo[0];
         e[1] = bb[1] & ~turbo[1];
      end
`endif
      return e;
   endfunction

   // Host-visible bit after k pulses: button k active-low, then zeros once eight bits are used.
   function automatic logic exp_bit(input logic [7:0] e, input int k);
      if (k < 8) return ~e[k];
      return 1'b0;
   endfunction

   // Per-cycle comparison of the outputs against the model while the host deems them settled.
   always @(negedge clk) begin
      if (chk_en) begin
         check("data_out", {31'd0, data_out}, {31'd0, exp_d});
         check("busy", {31'd0, busy}, {31'd0, exp_b});
      end
      if (frame_done === 1'b1) begin
         fd_cnt++;
         check("frame_done_data", {31'd0, data_out}, 32'd0);
         check("frame_done_busy", {31'd0, busy}, 32'd0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic settle(input logic d, input logic bz);
      tick(5);
      exp_d  = d;
      exp_b  = bz;
      chk_en = 1'b1;
      tick(2);
      chk_en = 1'b0;
      last_d = data_out;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      tick(n);
      reset = 1'b0;
`ifdef N8_TURBO_EN
      mframes = 0;
`endif
   endtask

   task automatic frame(input logic [7:0] b_rise, input logic [7:0] b_fall, input int np, input bit combo);
      logic [7:0] e;
      int         fd0;
      fd0     = fd_cnt;
      seq     = '1;
      btn     = b_rise;
      ltch_in = 1'b1;
      if (combo) pulse_in = 1'b1;
      tick(3);
      btn = b_fall;
      e   = eff_btn(b_fall);
      settle(exp_bit(e, 0), 1'b1);
      seq[0]   = last_d;
      ltch_in  = 1'b0;
      pulse_in = 1'b0;
`ifdef N8_TURBO_EN
      mframes++;
`endif
      settle(exp_bit(e, 0), 1'b1);
      for (int k = 1; k <= np; k++) begin
         pulse_in = 1'b1;
         settle(exp_bit(e, k), k < 8);
         if (k < 9) seq[k] = last_d;
         pulse_in = 1'b0;
         settle(exp_bit(e, k), k < 8);
      end
      check("frame_done_count", fd_cnt - fd0, (np >= 8) ? 32'd1 : 32'd0);
   endtask

   initial begin
      int fd0;
      reset    = 1'b1;
      ltch_in  = 1'b0;
      pulse_in = 1'b0;
      btn      = 8'd0;
`ifdef N8_TURBO_EN
      turbo    = 2'b00;
      mframes  = 0;
`endif
      do_reset(3);
      check("reset_data_out", {31'd0, data_out}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_frame_done", {31'd0, frame_done}, 32'd0);

      // A and Right pressed, nine pulses.
      frame(8'b1000_0001, 8'b1000_0001, 9, 1'b0);
      check("a_right_sequence", {23'd0, seq}, {23'd0, 9'b0_0011_1111_0});

      // Up changes while latch is held; the value at the fall wins.
      frame(8'b0000_0000, 8'b0001_0000, 8, 1'b0);
      check("up_late_bit4", {31'd0, seq[4]}, 32'd0);
      check("up_late_bit3", {31'd0, seq[3]}, 32'd1);

      // Stall after three pulses and let the watchdog fire.
      fd0 = fd_cnt;
      frame(8'h5a, 8'h5a, 3, 1'b0);
      tick(TO - 12);
      check("busy_before_timeout", {31'd0, busy}, 32'd1);
      tick(20);
      check("timeout_busy", {31'd0, busy}, 32'd0);
      check("timeout_data_out", {31'd0, data_out}, 32'd1);
      check("timeout_no_frame_done", fd_cnt - fd0, 32'd0);

      // Latch rise coincident with pulse rise at idx 5.
      frame(8'h3c, 8'h3c, 5, 1'b0);
      frame(8'hc5, 8'hc5, 8, 1'b1);
      check("combo_first_bit", {31'd0, seq[0]}, 32'd0);

      // Reset mid-frame at idx 4, then a clean frame.
      frame(8'h96, 8'h96, 4, 1'b0);
      do_reset(1);
      check("midreset_data_out", {31'd0, data_out}, 32'd1);
      check("midreset_busy", {31'd0, busy}, 32'd0);
      frame(8'h69, 8'h69, 8, 1'b0);

      // Randomized frames of random length.
      for (int i = 0; i < 20; i++) begin
         logic [7:0] rb;
         rb = 8'($urandom);
`ifdef N8_TURBO_EN
         turbo = 2'($urandom);
`endif
         frame(rb, rb, int'($urandom_range(0, 10)), 1'b0);
      end

`ifdef N8_TURBO_EN
      begin
         logic [7:0] tp;
         do_reset(1);
         turbo = 2'b01;
         for (int i = 0; i < 8; i++) begin
            frame(8'h01, 8'h01, 1, 1'b0);
            tp[i] = seq[0];
         end
         check("turbo_a_pattern", {24'd0, tp}, 32'h0000_00cc);
         turbo = 2'b00;
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/n8_pad_responder.md
# n8_pad_responder

Controller-side responder for the N8 serial pad protocol. It samples eight active-high button inputs and answers a host's latch/pulse sequence by shifting the button states out, active-low, on a single data line. The block sits on the FPGA fabric and emulates a physical pad toward an external console or a second FPGA running the host-side reader.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50000: number of `clk` cycles without a sync'd latch or pulse edge, while shifting, before the block aborts to IDLE.
- `TURBO_DIV`, default 4: number of latch frames per turbo half-period. Used only with `N8_TURBO_EN`.

Ports (clock and reset first):
- `clk` input 1: system clock. The block uses this single clock only.
- `reset` input 1: synchronous, active-high reset.
- `ltch_in` input 1: latch from the host, asynchronous.
- `pulse_in` input 1: shift clock from the host, asynchronous.
- `a`, `b`, `select`, `start`, `up`, `down`, `left`, `right` input 1 each: button pressed = 1.
- `turbo_a`, `turbo_b` input 1 each: autofire enables. These ports exist only with `N8_TURBO_EN`.
- `data_out` output 1: serial data to the host. Low means pressed.
- `busy` output 1: high in LOAD and SHIFT.
- `frame_done` output 1: one-cycle pulse when the 8th bit has been shifted past.

## Operation
- `ltch_in` and `pulse_in` each pass through a 2-flop synchronizer, then a registered edge detector (`ltch_s`, `pulse_s`, rise/fall flags).
- Snapshot register `snap[7:0]` holds bits in this order: bit0 = A, then B, Select, Start, Up, Down, Left, Right.
- 3-bit bit index `idx`. `data_out = ~snap[idx]` in LOAD and SHIFT.
- States:
  - IDLE: `data_out` = 1. Latch rise → LOAD.
  - LOAD: `snap` reloads from the buttons every cycle while `ltch_s` = 1. `idx` = 0. Latch fall → SHIFT. The last sampled value is kept.
  - SHIFT: on each pulse rise, `idx` increments. On the pulse rise where `idx` = 7, go to EXHAUSTED and assert `frame_done` for one cycle. Latch rise → LOAD.
  - EXHAUSTED: `data_out` = 0, so the host reads extra bits as 1s. Latch rise → LOAD.
- Watchdog:
  - A counter is cleared on every sync'd edge and counts only in SHIFT.
  - When it reaches `TIMEOUT_CYCLES`-1: go to IDLE, `data_out` = 1, no `frame_done`.
- Priority rules:
  - Latch rise beats any simultaneous pulse rise.
  - Pulse edges in IDLE, LOAD or EXHAUSTED are ignored.
  - Glitches on `pulse_in` shorter than 2 `clk` cycles may be lost; this is by design.
- Reset, including mid-frame:
  - State goes to IDLE; `data_out` = 1, `busy` = 0, `frame_done` = 0.
  - `snap` = 0, `idx` = 0, watchdog = 0, synchronizers cleared to 0.

## Timing
- `ltch_in`/`pulse_in` to internal edge flag: 3 `clk` cycles (2 sync + 1 edge register).
- `data_out` is registered. It updates 1 cycle after the edge flag, 4 `clk` cycles after the input pin edge.
- First bit (A) is valid on `data_out` 4 cycles after the latch rise and stays stable through the latch fall.
- Host requirement: latch high ≥ 4 `clk` cycles; pulse high and low ≥ 3 `clk` cycles each; host samples `data_out` ≥ 5 `clk` cycles after its pulse rise.
- `frame_done` is coincident with the cycle where `data_out` goes to 0 for EXHAUSTED.
- `busy` rises with entry to LOAD and falls on entry to EXHAUSTED or IDLE.

## Configuration
- `N8_TURBO_EN` defined:
  - Adds `turbo_a`/`turbo_b` and a frame counter that increments on each LOAD→SHIFT transition.
  - A turbo phase bit toggles every `TURBO_DIV` frames; phase resets to 0.
  - Loaded A = `a & ~(turbo_a & phase)`; B is formed the same way.
- Undefined: no turbo ports or counter; A and B load directly.

## Test plan
- Reset, then latch pulse, then 8 pulses with only A=1 and Right=1 → `data_out` sequence 0,1,1,1,1,1,1,0; `frame_done` once on the 8th pulse; 9th pulse reads `data_out` = 0.
- Change `up` from 0 to 1 while latch is high, then drop latch → the value at latch fall is used: bit 4 reads 0 (pressed).
- Stop after 3 pulses and wait `TIMEOUT_CYCLES` → IDLE, `data_out` = 1, `busy` = 0, no `frame_done`.
- Latch rise and pulse rise on the same cycle during SHIFT (`idx` = 5) → LOAD, `idx` = 0, `data_out` = ~A.
- Assert `reset` for 1 cycle mid-frame at `idx` = 4 → next cycle `data_out` = 1, `busy` = 0; the next full frame reads correctly.
- With `N8_TURBO_EN`, `TURBO_DIV` = 2, `a` = 1, `turbo_a` = 1 over 8 frames → A read as pressed,pressed,released,released,pressed,pressed,released,released.
